ps2_note_decoder: RTL and testbench

Downstream consumer of the PS/2 receive stage: takes each single-cycle `isValid` pulse with its 8-bit scan code `KCode` and turns the scan-code set 2 make/break sequences into piano note-on and note-off events. Events are queued in a 4-entry FIFO behind a valid/ready handshake for the note sequencer and tone generator. The block also tracks which piano keys are held and keeps an octave register that two dedicated keys step up and down.

---
 rtl/ps2_note_decoder.sv | 136 +++++++++++++
 tb/tb_ps2_note_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code set 2 to piano note event decoder.
// Turns make/break sequences into note-on/off events, which wait in a small FIFO
// behind a valid/ready handshake. It also tracks which keys are held and keeps an
// octave register.
// Optional build macro: TYPEMATIC_FILTER_EN. When defined, a repeated make code for a
// key that is already held produces no event.
module ps2_note_decoder #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned OCTAVE_RESET = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  KCode,
  input  logic        isValid,
  input  logic        EventReady,
  output logic        EventValid,
  output logic [6:0]  EventNote,
  output logic        EventOn,
  output logic [12:0] HeldKeys,
  output logic [2:0]  Octave,
  output logic        Overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e          state;
  logic [6:0]      mem_note [FIFO_DEPTH];
  logic            mem_on   [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [PtrW:0]   count;

  logic            key_hit;
  logic [3:0]      key_idx;
  logic            is_make, is_break, repeat_blocked;
  logic            push, pop, full, write;
  logic [6:0]      push_note;

  // Map a set-2 code onto a piano key index.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (KCode)
      8'h1C: key_idx = 4'd0;
      8'h1D: key_idx = 4'd1;
      8'h1B: key_idx = 4'd2;
      8'h24: key_idx = 4'd3;
      8'h23: key_idx = 4'd4;
      8'h2B: key_idx = 4'd5;
      8'h2C: key_idx = 4'd6;
      8'h34: key_idx = 4'd7;
      8'h35: key_idx = 4'd8;
      8'h33: key_idx = 4'd9;
      8'h3C: key_idx = 4'd10;
      8'h3B: key_idx = 4'd11;
      8'h42: key_idx = 4'd12;
      default: key_hit = 1'b0;
    endcase
  end

`ifdef TYPEMATIC_FILTER_EN
  assign repeat_blocked = HeldKeys[key_idx];
`else
  assign repeat_blocked = 1'b0;
`endif

  // Classify the incoming byte and work out whether it produces an event.
  always_comb begin
    is_make   = isValid && (state == StIdle) && (KCode != 8'hF0) && (KCode != 8'hE0);
    is_break  = isValid && (state == StBrk);
    push      = key_hit && ((is_make && !repeat_blocked) || is_break);
    push_note = {4'd0, Octave} * 7'd12 + {3'd0, key_idx};
    pop       = EventValid && EventReady;
    full      = (count == FullCount);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    write     = push && (!full || pop);
  end

  assign EventValid = (count != '0);
  assign EventNote  = mem_note[rd_ptr];
  assign EventOn    = mem_on[rd_ptr];

  // Prefix FSM, held keys, octave, and FIFO state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= StIdle;
      HeldKeys <= '0;
      Octave   <= 3'(OCTAVE_RESET);
      Overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_note[i] <= '0;
        mem_on[i]   <= 1'b0;
      end
    end else begin
      if (isValid) begin
        case (state)
          StIdle:   if (KCode == 8'hF0) state <= StBrk;
                    else if (KCode == 8'hE0) state <= StExt;
          StBrk:    state <= StIdle;
          StExt:    state <= (KCode == 8'hF0) ? StExtBrk : StIdle;
          default:  state <= StIdle;
        endcase
      end

      if (is_make && key_hit) HeldKeys[key_idx] <= 1'b1;
      if (is_break && key_hit) HeldKeys[key_idx] <= 1'b0;

      // Octave only moves with no keys held, so note-offs always match their note-ons.
      if (is_make && (HeldKeys == '0)) begin
        if (KCode == 8'h22 && Octave != 3'd7) Octave <= Octave + 3'd1;
        if (KCode == 8'h1A && Octave != 3'd0) Octave <= Octave - 3'd1;
      end

      if (push && !write) Overflow <= 1'b1;

      if (write) begin
        mem_note[wr_ptr] <= push_note;
        mem_on[wr_ptr]   <= is_make;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Randomised bench for ps2_note_decoder against a queue-based reference model.
// Build with +define+TYPEMATIC_FILTER_EN to exercise the auto-repeat filter.
module tb_ps2_note_decoder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  KCode = 8'h00;
  logic        isValid = 1'b0;
  logic        EventReady = 1'b0;
  logic        EventValid;
  logic [6:0]  EventNote;
  logic        EventOn;
  logic [12:0] HeldKeys;
  logic [2:0]  Octave;
  logic        Overflow;

  ps2_note_decoder #(.FIFO_DEPTH(4), .OCTAVE_RESET(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KCode      (KCode),
    .isValid    (isValid),
    .EventReady (EventReady),
    .EventValid (EventValid),
    .EventNote  (EventNote),
    .EventOn    (EventOn),
    .HeldKeys   (HeldKeys),
    .Octave     (Octave),
    .Overflow   (Overflow)
  );

  always #5 Clock = ~Clock;

  // Reference model state.
  logic [7:0]  key_map [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  logic [7:0]  ev_q [$];  // {on, note}
  logic [12:0] m_held;
  int          m_oct;
  bit          m_ovf, saw_e0, saw_f0;
  bit          filter_en;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] code);
    for (int i = 0; i < 13; i++) if (key_map[i] == code) return i;
    return -1;
  endfunction

  task automatic model_push(input int note, input bit on, input bit popped);
    if (ev_q.size() == 4 && !popped) m_ovf = 1'b1;
    else ev_q.push_back({on, 7'(note)});
  endtask

  task automatic model_step(input bit rst, input bit vld, input logic [7:0] code,
                            input bit rdy);
    bit popped;
    int idx;
    if (rst) begin
      ev_q.delete();
      m_held = '0; m_oct = 4; m_ovf = 1'b0; saw_e0 = 1'b0; saw_f0 = 1'b0;
      return;
    end
    popped = (ev_q.size() > 0) && rdy;
    if (popped) void'(ev_q.pop_front());
    if (!vld) return;
    idx = lookup(code);
    if (saw_f0) begin
      // Byte after F0: a break code, unless the sequence began with E0.
      if (!saw_e0 && idx >= 0) begin
        m_held[idx] = 1'b0;
        model_push(m_oct * 12 + idx, 1'b0, popped);
      end
      saw_e0 = 1'b0; saw_f0 = 1'b0;
    end else if (code == 8'hF0) begin
      saw_f0 = 1'b1;
    end else if (saw_e0) begin
      saw_e0 = 1'b0;
    end else if (code == 8'hE0) begin
      saw_e0 = 1'b1;
    end else begin
      if (idx >= 0) begin
        if (!(filter_en && m_held[idx])) model_push(m_oct * 12 + idx, 1'b1, popped);
        m_held[idx] = 1'b1;
      end else if (m_held == '0) begin
        if (code == 8'h22 && m_oct < 7) m_oct++;
        if (code == 8'h1A && m_oct > 0) m_oct--;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit vld, input logic [7:0] code, input bit rdy);
    @(negedge Clock);
    Reset = rst; isValid = vld; KCode = code; EventReady = rdy;
    @(posedge Clock);
    model_step(rst, vld, code, rdy);
    #1;
    check_eq("EventValid", 32'(EventValid), 32'(ev_q.size() != 0));
    if (ev_q.size() != 0) begin
      check_eq("EventNote", 32'(EventNote), 32'(ev_q[0][6:0]));
      check_eq("EventOn", 32'(EventOn), 32'(ev_q[0][7]));
    end
    if (rst) begin
      check_eq("reset EventNote", 32'(EventNote), 32'd0);
      check_eq("reset EventOn", 32'(EventOn), 32'd0);
    end
    check_eq("HeldKeys", 32'(HeldKeys), 32'(m_held));
    check_eq("Octave", 32'(Octave), 32'(m_oct));
    check_eq("Overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  task automatic send(input logic [7:0] code, input bit rdy);
    cycle(1'b0, 1'b1, code, rdy);
  endtask

  initial begin
    int rdy_pct;
    int r;
    logic [7:0] code;
`ifdef TYPEMATIC_FILTER_EN
    filter_en = 1'b1;
`else
    filter_en = 1'b0;
`endif
    // Reset with a simultaneous isValid that must be ignored.
    cycle(1'b1, 1'b1, 8'h1C, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Basic make/break of key 0 at octave 4.
    send(8'h1C, 1'b0);
    check_eq("plan make note", 32'(EventNote), 32'd48);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Octave up, then key 42 at octave 5, saturation, blocked octave down.
    send(8'h22, 1'b1); send(8'hF0, 1'b1); send(8'h22, 1'b1);
    send(8'h42, 1'b0);
    check_eq("plan octave note", 32'(EventNote), 32'd72);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    send(8'hF0, 1'b1); send(8'h42, 1'b1);
    repeat (4) begin send(8'h22, 1'b1); send(8'hF0, 1'b1); send(8'h22, 1'b1); end
    check_eq("plan octave sat", 32'(Octave), 32'd7);
    send(8'h42, 1'b1);
    send(8'h1A, 1'b1);
    send(8'hF0, 1'b1); send(8'h42, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Extended sequences produce nothing.
    send(8'hE0, 1'b1); send(8'h1C, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);

    // Overflow: six makes with the consumer stalled, then drain.
    for (int i = 0; i < 6; i++) send(key_map[i], 1'b0);
    check_eq("plan overflow", 32'(Overflow), 32'd1);
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Auto-repeat of key 0.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) send(8'h1C, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset straight after F0 abandons the break.
    send(8'hF0, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    send(8'h1C, 1'b0);
    check_eq("plan reset mid-seq", 32'({EventOn, EventNote}), 32'({1'b1, 7'd48}));

    // Random traffic.
    rdy_pct = 80;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rdy_pct = (n % 300 == 0) ? 0 : ((n % 200 == 0) ? 30 : 90);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: code = key_map[$urandom_range(0, 12)];
        5: code = 8'hF0;
        6: code = 8'hE0;
        7: code = 8'h22;
        8: code = 8'h1A;
        default: code = 8'($urandom_range(0, 255));
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, code,
            $urandom_range(0, 99) < rdy_pct);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
